// File: rtl/nand_page_packer.sv
// Packs a NAND page byte stream into little-endian 32-bit SRAM words, padding the tail word with 8'hFF.
// Optional running byte checksum: define NAND_PACKER_CHECKSUM_EN.
module nand_page_packer #(
    parameter int PAGE_BYTES = 2112,
    parameter int ADDR_W     = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PAGE_START,
    input  logic [7:0]        DIN,
    input  logic              DIN_VALID,
    output logic [ADDR_W-1:0] WADDR,
    output logic [31:0]       WD,
    output logic              WEN,
    output logic              BUSY,
    output logic              PAGE_DONE,
    output logic              OVERFLOW,
    output logic [15:0]       CHECKSUM
);
    localparam int               CNT_W = $clog2(PAGE_BYTES + 1);
    localparam int               REM   = PAGE_BYTES % 4;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PAGE_BYTES - 1);

    typedef enum logic [1:0] {IDLE, FILL, FLUSH, DONE} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_widx;
    logic [23:0]       r_part;
    logic              r_seen;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wd;
    logic              r_wen;
    logic              r_busy;
    logic              r_done;
    logic              r_ovf;

    // A PAGE_START restarts from byte 0 in any state, so the byte taken in
    // that cycle must see freshly cleared counters rather than the registers.
    logic              w_take;
    logic [CNT_W-1:0]  w_idx;
    logic [ADDR_W-1:0] w_widx;
    logic [23:0]       w_part;
    logic [23:0]       w_part_nxt;
    logic [1:0]        w_lane;

    assign w_take = DIN_VALID && (PAGE_START || r_state == FILL);
    assign w_idx  = PAGE_START ? '0 : r_cnt;
    assign w_widx = PAGE_START ? '0 : r_widx;
    assign w_part = PAGE_START ? 24'hFFFFFF : r_part;
    assign w_lane = 2'(w_idx);

    always_comb begin
        w_part_nxt = w_part;
        case (w_lane)
            2'd0:    w_part_nxt[7:0]   = DIN;
            2'd1:    w_part_nxt[15:8]  = DIN;
            2'd2:    w_part_nxt[23:16] = DIN;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_widx  <= '0;
            r_part  <= 24'hFFFFFF;
            r_seen  <= 1'b0;
            r_waddr <= '0;
            r_wd    <= '0;
            r_wen   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_wen  <= 1'b0;
            r_done <= 1'b0;
            if (PAGE_START) begin
                r_state <= FILL;
                r_busy  <= 1'b1;
                r_ovf   <= 1'b0;
                r_cnt   <= '0;
                r_widx  <= '0;
                r_part  <= 24'hFFFFFF;
            end
            if (w_take) begin
                r_cnt <= w_idx + CNT_W'(1);
                if (w_lane == 2'd3) begin
                    r_wen   <= 1'b1;
                    r_waddr <= w_widx;
                    r_wd    <= {DIN, w_part};
                    r_widx  <= w_widx + ADDR_W'(1);
                    r_part  <= 24'hFFFFFF;
                end else begin
                    r_part <= w_part_nxt;
                end
                if (w_idx == LAST) begin
                    if (REM != 0) begin
                        r_state <= FLUSH;
                    end else begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                    end
                end
            end else if (!PAGE_START) begin
                case (r_state)
                    IDLE: if (DIN_VALID && r_seen) r_ovf <= 1'b1;
                    FLUSH: begin
                        // unfilled lanes still hold the erased pattern
                        r_wen   <= 1'b1;
                        r_waddr <= r_widx;
                        r_wd    <= {8'hFF, r_part};
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        if (DIN_VALID) r_ovf <= 1'b1;
                    end
                    DONE: begin
                        r_done  <= 1'b1;
                        r_seen  <= 1'b1;
                        r_state <= IDLE;
                        if (DIN_VALID) r_ovf <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef NAND_PACKER_CHECKSUM_EN
    logic [15:0] r_sum;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sum <= '0;
        end else if (w_take) begin
            r_sum <= (PAGE_START ? 16'h0000 : r_sum) + {8'h00, DIN};
        end else if (PAGE_START) begin
            r_sum <= '0;
        end
    end

    assign CHECKSUM = r_sum;
`else
    assign CHECKSUM = 16'h0000;
`endif

    assign WADDR     = r_waddr;
    assign WD        = r_wd;
    assign WEN       = r_wen;
    assign BUSY      = r_busy;
    assign PAGE_DONE = r_done;
    assign OVERFLOW  = r_ovf;

endmodule

// File: tb/tb_nand_page_packer.sv
// Bench for nand_page_packer: a 2112-byte instance and a 6-byte instance checked against
// an SRAM image built from the byte list; honours NAND_PACKER_CHECKSUM_EN when defined.
module tb_nand_page_packer;
    logic        CLK;
    logic        RST;

    logic        st_a, dv_a;
    logic [7:0]  din_a;
    logic [9:0]  waddr_a;
    logic [31:0] wd_a;
    logic        wen_a, busy_a, pd_a, ovf_a;
    logic [15:0] cs_a;

    logic        st_b, dv_b;
    logic [7:0]  din_b;
    logic [1:0]  waddr_b;
    logic [31:0] wd_b;
    logic        wen_b, busy_b, pd_b, ovf_b;
    logic [15:0] cs_b;

    nand_page_packer #(.PAGE_BYTES(2112), .ADDR_W(10)) u_a (
        .CLK(CLK), .RST(RST), .PAGE_START(st_a), .DIN(din_a), .DIN_VALID(dv_a),
        .WADDR(waddr_a), .WD(wd_a), .WEN(wen_a), .BUSY(busy_a),
        .PAGE_DONE(pd_a), .OVERFLOW(ovf_a), .CHECKSUM(cs_a)
    );

    nand_page_packer #(.PAGE_BYTES(6), .ADDR_W(2)) u_b (
        .CLK(CLK), .RST(RST), .PAGE_START(st_b), .DIN(din_b), .DIN_VALID(dv_b),
        .WADDR(waddr_b), .WD(wd_b), .WEN(wen_b), .BUSY(busy_b),
        .PAGE_DONE(pd_b), .OVERFLOW(ovf_b), .CHECKSUM(cs_b)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int cyc = 0;
    always @(posedge CLK) cyc++;

    // SRAM images and event records, written only by the monitor
    logic [31:0] sram_a [0:1023];
    int          wen_cyc_a [0:1023];
    int          wen_cnt_a = 0, done_cnt_a = 0, done_cyc_a = 0, max_a = 0;
    logic [15:0] sum_a = 16'h0;
    logic [31:0] sram_b [0:3];
    int          wen_cyc_b [0:3];
    int          wen_cnt_b = 0, done_cnt_b = 0, done_cyc_b = 0;
    logic [15:0] sum_b = 16'h0;

    always @(negedge CLK) begin
        if (wen_a === 1'b1) begin
            sram_a[waddr_a]    = wd_a;
            wen_cyc_a[waddr_a] = cyc;
            wen_cnt_a++;
            if (int'(waddr_a) > max_a) max_a = int'(waddr_a);
        end
        if (pd_a === 1'b1) begin
            done_cnt_a++;
            done_cyc_a = cyc;
            sum_a      = cs_a;
        end
        if (wen_b === 1'b1) begin
            sram_b[waddr_b]    = wd_b;
            wen_cyc_b[waddr_b] = cyc;
            wen_cnt_b++;
        end
        if (pd_b === 1'b1) begin
            done_cnt_b++;
            done_cyc_b = cyc;
            sum_b      = cs_b;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int drv_last_a [0:1023];
    int drv_b [0:5];
    logic [7:0] pg [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: word k is bytes 4k..4k+3 of the page, little-endian, erased beyond the end
    function automatic logic [31:0] exp_word(input int k);
        logic [31:0] w;
        for (int n = 0; n < 4; n++) begin
            int i;
            i = 4 * k + n;
            w[8*n +: 8] = (i < pg.size()) ? pg[i] : 8'hFF;
        end
        return w;
    endfunction

    function automatic logic [15:0] exp_sum();
        logic [15:0] s;
        s = 16'h0;
`ifdef NAND_PACKER_CHECKSUM_EN
        foreach (pg[i]) s = s + 16'(pg[i]);
`endif
        return s;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_a();
        st_a = 1'b1;
        step();
        st_a = 1'b0;
    endtask

    task automatic send_a(input logic [7:0] b, input bit st, input int idx);
        st_a  = st;
        din_a = b;
        dv_a  = 1'b1;
        if (idx % 4 == 3) drv_last_a[idx/4] = cyc;
        step();
        st_a = 1'b0;
        dv_a = 1'b0;
    endtask

    task automatic run_page_a(input bit rnd, input bit st_first);
        if (!st_first) pulse_a();
        for (int i = 0; i < pg.size(); i++) begin
            if (rnd) repeat ($urandom_range(0, 2)) step();
            send_a(pg[i], st_first && (i == 0), i);
        end
    endtask

    task automatic wait_done_a(input int base, input string tag);
        int n;
        n = 0;
        while (done_cnt_a == base && n < 50) begin
            step();
            n++;
        end
        chk(tag, 32'(done_cnt_a != base), 32'd1);
    endtask

    task automatic check_page_a(input string tag);
        for (int k = 0; k < 528; k++) begin
            chk({tag, "_word"}, sram_a[k], exp_word(k));
            chk({tag, "_wen_lat"}, 32'(wen_cyc_a[k] - drv_last_a[k]), 32'd1);
        end
        chk({tag, "_done_after_last_wen"}, 32'(done_cyc_a - wen_cyc_a[527]), 32'd1);
        chk({tag, "_cksum"}, 32'(sum_a), 32'(exp_sum()));
        chk({tag, "_busy_low"}, 32'(busy_a), 32'd0);
        chk({tag, "_waddr_hold"}, 32'(waddr_a), 32'd527);
        chk({tag, "_wd_hold"}, wd_a, exp_word(527));
    endtask

    initial begin
        int w0, d0;
        st_a = 1'b0; dv_a = 1'b0; din_a = 8'h00;
        st_b = 1'b0; dv_b = 1'b0; din_b = 8'h00;
        RST  = 1'b1;
        repeat (3) step();

        chk("rst_waddr", 32'(waddr_a), 32'd0);
        chk("rst_wd", wd_a, 32'd0);
        chk("rst_wen", 32'(wen_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(pd_a), 32'd0);
        chk("rst_ovf", 32'(ovf_a), 32'd0);
        chk("rst_cksum", 32'(cs_a), 32'd0);
        RST = 1'b0;
        step();

        // bytes before any page has ever started are ignored silently
        w0 = wen_cnt_a;
        for (int i = 0; i < 6; i++) send_a(8'($urandom), 1'b0, 0);
        step();
        chk("prepage_ovf", 32'(ovf_a), 32'd0);
        chk("prepage_wen", 32'(wen_cnt_a - w0), 32'd0);
        chk("prepage_busy", 32'(busy_a), 32'd0);

        // back-to-back ramp page
        pg.delete();
        for (int i = 0; i < 2112; i++) pg.push_back(8'(i));
        w0 = wen_cnt_a; d0 = done_cnt_a;
        pulse_a();
        chk("start_busy", 32'(busy_a), 32'd1);
        run_page_a(1'b0, 1'b0);
        wait_done_a(d0, "seq_done_seen");
        step();
        check_page_a("seq");
        chk("seq_word0", sram_a[0], 32'h03020100);
        chk("seq_wen_cnt", 32'(wen_cnt_a - w0), 32'd528);
        chk("seq_done_cnt", 32'(done_cnt_a - d0), 32'd1);
        chk("seq_max_addr", 32'(max_a), 32'd527);
        chk("seq_ovf", 32'(ovf_a), 32'd0);

        // same page with DIN_VALID toggling at random
        w0 = wen_cnt_a; d0 = done_cnt_a;
        run_page_a(1'b1, 1'b0);
        wait_done_a(d0, "rnd_done_seen");
        step();
        check_page_a("rnd");
        chk("rnd_wen_cnt", 32'(wen_cnt_a - w0), 32'd528);
        chk("rnd_done_cnt", 32'(done_cnt_a - d0), 32'd1);

        // abort after 10 bytes, restart with byte 0 in the PAGE_START cycle
        w0 = wen_cnt_a; d0 = done_cnt_a;
        pulse_a();
        for (int i = 0; i < 10; i++) send_a(8'($urandom), 1'b0, i);
        repeat (3) step();
        chk("abort_partial_wen", 32'(wen_cnt_a - w0), 32'd2);
        pg.delete();
        for (int i = 0; i < 2112; i++) pg.push_back(8'($urandom));
        run_page_a(1'b0, 1'b1);
        wait_done_a(d0, "abort_done_seen");
        step();
        check_page_a("abort");
        chk("abort_wen_cnt", 32'(wen_cnt_a - w0), 32'd530);
        chk("abort_done_cnt", 32'(done_cnt_a - d0), 32'd1);
        chk("abort_max_addr", 32'(max_a), 32'd527);

        // bytes after a completed page
        w0 = wen_cnt_a;
        for (int i = 0; i < 3; i++) send_a(8'($urandom), 1'b0, 0);
        step();
        chk("ovf_set", 32'(ovf_a), 32'd1);
        chk("ovf_no_wen", 32'(wen_cnt_a - w0), 32'd0);
        chk("ovf_busy", 32'(busy_a), 32'd0);
        repeat (2) step();
        chk("ovf_sticky", 32'(ovf_a), 32'd1);
        pulse_a();
        chk("ovf_clear", 32'(ovf_a), 32'd0);

        // asynchronous reset in the middle of word 250
        w0 = wen_cnt_a;
        pulse_a();
        for (int i = 0; i < 1001; i++) send_a(8'(i * 7 + 1), 1'b0, i);
        din_a = 8'h5A;
        dv_a  = 1'b1;
        #2 RST = 1'b1;
        #1;
        chk("arst_waddr", 32'(waddr_a), 32'd0);
        chk("arst_wd", wd_a, 32'd0);
        chk("arst_wen", 32'(wen_a), 32'd0);
        chk("arst_busy", 32'(busy_a), 32'd0);
        chk("arst_done", 32'(pd_a), 32'd0);
        chk("arst_ovf", 32'(ovf_a), 32'd0);
        chk("arst_cksum", 32'(cs_a), 32'd0);
        step();
        dv_a = 1'b0;
        step();
        RST = 1'b0;
        step();
        for (int i = 0; i < 8; i++) send_a(8'($urandom), 1'b0, 0);
        repeat (2) step();
        chk("arst_wen_cnt", 32'(wen_cnt_a - w0), 32'd250);
        chk("arst_need_start", 32'(busy_a), 32'd0);
        chk("arst_no_ovf", 32'(ovf_a), 32'd0);

        // page of 8'h01 started with byte 0 in the PAGE_START cycle
        pg.delete();
        for (int i = 0; i < 2112; i++) pg.push_back(8'h01);
        w0 = wen_cnt_a; d0 = done_cnt_a;
        run_page_a(1'b0, 1'b1);
        wait_done_a(d0, "ones_done_seen");
        step();
        check_page_a("ones");
        chk("ones_wen_cnt", 32'(wen_cnt_a - w0), 32'd528);
`ifdef NAND_PACKER_CHECKSUM_EN
        chk("ones_cksum_const", 32'(sum_a), 32'h0840);
`else
        chk("ones_cksum_tied", 32'(sum_a), 32'h0000);
`endif
        repeat (3) step();
        chk("ones_cksum_hold", 32'(cs_a), 32'(exp_sum()));

        // short page with a padded final word
        pg.delete();
        pg.push_back(8'hAA); pg.push_back(8'hBB); pg.push_back(8'hCC);
        pg.push_back(8'hDD); pg.push_back(8'hEE); pg.push_back(8'h11);
        w0 = wen_cnt_b; d0 = done_cnt_b;
        for (int i = 0; i < 6; i++) begin
            st_b   = (i == 0);
            din_b  = pg[i];
            dv_b   = 1'b1;
            drv_b[i] = cyc;
            step();
            st_b = 1'b0;
            dv_b = 1'b0;
        end
        begin
            int n;
            n = 0;
            while (done_cnt_b == d0 && n < 20) begin
                step();
                n++;
            end
        end
        chk("b_done_seen", 32'(done_cnt_b - d0), 32'd1);
        step();
        chk("b_word0", sram_b[0], 32'hDDCCBBAA);
        chk("b_word1", sram_b[1], 32'hFFFF11EE);
        chk("b_word1_model", sram_b[1], exp_word(1));
        chk("b_wen_cnt", 32'(wen_cnt_b - w0), 32'd2);
        chk("b_wen0_lat", 32'(wen_cyc_b[0] - drv_b[3]), 32'd1);
        chk("b_flush_lat", 32'(wen_cyc_b[1] - drv_b[5]), 32'd2);
        chk("b_done_lat", 32'(done_cyc_b - wen_cyc_b[1]), 32'd1);
        chk("b_cksum", 32'(sum_b), 32'(exp_sum()));
        chk("b_busy", 32'(busy_b), 32'd0);
        chk("b_waddr_hold", 32'(waddr_b), 32'd1);
        chk("b_ovf", 32'(ovf_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nand_page_packer.md
NAND_PAGE_PACKER -- requirements
Module: nand_page_packer

Interface
REQ-001 The block SHALL have parameter PAGE_BYTES, default 2112, meaning the number of bytes in one NAND page (main plus spare area).
REQ-002 The block SHALL have parameter ADDR_W, default 10, meaning the word-address width of the downstream two-port page SRAM; ceil(PAGE_BYTES/4) SHALL NOT exceed 2^ADDR_W.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port PAGE_START, input, 1 bit: one-cycle pulse that begins a new page capture.
REQ-006 The block SHALL have port DIN, input, 8 bits: NAND read data byte.
REQ-007 The block SHALL have port DIN_VALID, input, 1 bit: DIN is valid this cycle.
REQ-008 The block SHALL have port WADDR, output, ADDR_W bits: SRAM write word address.
REQ-009 The block SHALL have port WD, output, 32 bits: SRAM write data.
REQ-010 The block SHALL have port WEN, output, 1 bit: SRAM write strobe, one word per high cycle.
REQ-011 The block SHALL have port BUSY, output, 1 bit: a page capture is in progress.
REQ-012 The block SHALL have port PAGE_DONE, output, 1 bit: one-cycle pulse after the last word of the page has been written.
REQ-013 The block SHALL have port OVERFLOW, output, 1 bit: sticky flag, set when bytes arrive after the page is complete.
REQ-014 The block SHALL have port CHECKSUM, output, 16 bits: running byte sum of the page (see Configuration).

Function
REQ-015 The block SHALL implement the states IDLE, FILL, FLUSH and DONE.
REQ-016 In IDLE, a PAGE_START pulse SHALL clear the byte counter, the word address and OVERFLOW, and SHALL move the block to FILL; BUSY SHALL be high in FILL and FLUSH.
REQ-017 In FILL, each cycle with DIN_VALID high SHALL accept one byte, packed little-endian: byte 4k+n goes to WD[8n+7:8n] of word k.
REQ-018 WEN SHALL go high for exactly one cycle, registered, in the cycle after the 4th byte of a word is accepted, with WADDR=k; there SHALL be no back-pressure, and a valid byte every cycle SHALL be sustained.
REQ-019 When byte PAGE_BYTES-1 is accepted, the block SHALL go to FLUSH if PAGE_BYTES mod 4 is nonzero, and to DONE otherwise.
REQ-020 FLUSH SHALL pad the unused bytes of the final word with 8'hFF (the erased value) and SHALL write the word with one WEN pulse, then go to DONE.
REQ-021 DONE SHALL assert PAGE_DONE for one cycle, with BUSY low, and SHALL then return to IDLE.
REQ-022 If PAGE_START and DIN_VALID are both high in IDLE, that DIN SHALL be accepted as byte 0.
REQ-023 A PAGE_START pulse in FILL, FLUSH or DONE SHALL abort the current page without writing the partial word and without a PAGE_DONE pulse, and SHALL restart at byte 0, word 0; a DIN_VALID in the same cycle SHALL be taken as byte 0.
REQ-024 A DIN_VALID in IDLE with no PAGE_START, after at least one page has completed, SHALL be discarded and SHALL set OVERFLOW.
REQ-025 OVERFLOW SHALL stay high until the next PAGE_START or RST; DIN_VALID before any page has started SHALL be discarded without setting OVERFLOW.
REQ-026 WADDR SHALL NOT wrap: its highest value SHALL be ceil(PAGE_BYTES/4)-1.
REQ-027 WD and WADDR SHALL hold their last values while WEN is low.

Reset
REQ-028 RST high SHALL force, asynchronously: the state to IDLE; WADDR=0, WD=0, WEN=0, BUSY=0, PAGE_DONE=0, OVERFLOW=0, CHECKSUM=0; and it SHALL clear the byte counter and the "page seen" flag.
REQ-029 After a reset mid-page, the block SHALL need a fresh PAGE_START before it accepts any data; no partial-word write SHALL be issued.

Configuration
REQ-030 With macro NAND_PACKER_CHECKSUM_EN defined, CHECKSUM SHALL be the 16-bit wrapping sum of all accepted bytes of the current page, excluding pad bytes.
REQ-031 With NAND_PACKER_CHECKSUM_EN defined, CHECKSUM SHALL be cleared on PAGE_START, SHALL be valid in the PAGE_DONE cycle, and SHALL hold its value until the next PAGE_START.
REQ-032 Without NAND_PACKER_CHECKSUM_EN, CHECKSUM SHALL be tied to 16'h0000 and the block SHALL contain no adder logic.

Verification
REQ-033 PAGE_BYTES=2112; PAGE_START, then bytes 0..2111 with value (i mod 256), one per cycle -> 528 WEN pulses, WADDR 0..527, word 0 = 32'h03020100, a single PAGE_DONE one cycle after the last WEN, OVERFLOW=0.
REQ-034 PAGE_BYTES=6; send bytes AA BB CC DD EE 11 -> word 0 = 32'hDDCCBBAA, word 1 = 32'hFFFF11EE written in FLUSH, then PAGE_DONE.
REQ-035 Bytes sent with DIN_VALID toggling at random -> the same SRAM contents as the back-to-back run, and the WEN count equals 528.
REQ-036 PAGE_START after 10 bytes -> no WEN for word 2 of the aborted page, and the new page starts at WADDR=0 -> the full page is captured correctly.
REQ-037 3 extra bytes after PAGE_DONE -> no WEN, OVERFLOW=1, and OVERFLOW is cleared by the next PAGE_START.
REQ-038 RST asserted mid-word at byte 1001 -> all outputs 0 within the same cycle; with NAND_PACKER_CHECKSUM_EN defined, a full page of bytes 8'h01 -> CHECKSUM=16'h0840.
